// File: rtl/fc_wb_loader.sv
// Byte-stream loader for the FC weight/bias SRAM: packs 26 bytes per 208-bit word
// and writes 20 consecutive words starting at BASE_ADDR, then reports completion.
module fc_wb_loader #(
    parameter int DATA_SIZE  = 8,
    parameter int WORD_BYTES = 26,
    parameter int WORD_WIDTH = 208,
    parameter int ADDR_WIDTH = 11,
    parameter int BASE_ADDR  = 1020,
    parameter int NUM_WORDS  = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  load_abort,
    input  logic [DATA_SIZE-1:0]  in_data,
    input  logic                  in_vld,
    output logic                  in_rdy,
    output logic                  wb_sram_enb,
    output logic                  wb_sram_web,
    output logic [ADDR_WIDTH-1:0] wb_sram_addrb,
    output logic [WORD_WIDTH-1:0] wb_sram_dinb,
    output logic                  load_busy,
    output logic                  load_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [4:0]            LAST_BYTE = 5'(WORD_BYTES - 1);
    localparam logic [4:0]            LAST_WORD = 5'(NUM_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

    logic [1:0]            state_q, state_d;
    logic [4:0]            byte_cnt_q, byte_cnt_d;
    logic [4:0]            word_idx_q, word_idx_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [WORD_WIDTH-1:0] dout_q, dout_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  accept;
    logic [WORD_WIDTH-1:0] shift_next;

    // Abort suppresses acceptance so a cancelled byte never enters the shift register.
    assign in_rdy     = (state_q == S_FILL);
    assign accept     = in_rdy & in_vld & ~load_abort;
    assign shift_next = {shift_q[WORD_WIDTH-DATA_SIZE-1:0], in_data};

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        shift_d    = shift_q;
        dout_d     = dout_q;
        addr_d     = addr_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (load_start && !load_abort) begin
                    state_d    = S_FILL;
                    byte_cnt_d = 5'd0;
                    word_idx_d = 5'd0;
                end
            end
            S_FILL: begin
                if (load_abort) begin
                    state_d    = S_IDLE;
                    byte_cnt_d = 5'd0;
                    word_idx_d = 5'd0;
                end else if (accept) begin
                    shift_d    = shift_next;
                    byte_cnt_d = byte_cnt_q + 5'd1;
                    // Output registers are loaded here so they hold through the next FILL.
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d = S_WRITE;
                        dout_d  = shift_next;
                        addr_d  = BASE + {{(ADDR_WIDTH-5){1'b0}}, word_idx_q};
                    end
                end
            end
            S_WRITE: begin
                byte_cnt_d = 5'd0;
                word_idx_d = word_idx_q + 5'd1;
                if (load_abort) begin
                    state_d    = S_IDLE;
                    word_idx_d = 5'd0;
                end else if (word_idx_q == LAST_WORD) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FILL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 5'd0;
            word_idx_q <= 5'd0;
            shift_q    <= '0;
            dout_q     <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            shift_q    <= shift_d;
            dout_q     <= dout_d;
            addr_q     <= addr_d;
        end
    end

    assign wb_sram_enb   = (state_q == S_WRITE);
    assign wb_sram_web   = (state_q == S_WRITE);
    assign wb_sram_addrb = addr_q;
    assign wb_sram_dinb  = dout_q;
    assign load_busy     = (state_q == S_FILL) || (state_q == S_WRITE);
    assign load_done     = (state_q == S_DONE);

endmodule

// File: doc/fc_wb_loader.md
Name: fc_wb_loader

Overview:
- Writer side of the FC weight/bias SRAM that the FC layer reads at base address 1020.
- Accepts a byte stream with a valid/ready handshake from the host/DMA front end.
- Packs each 26 received bytes into one 208-bit SRAM word: 200 weight bits, then 8 bias bits.
- Writes 20 such words (10 classes x 2 words) to consecutive addresses, then flags completion so the controller can raise the FC enable.

Parameters:
DATA_SIZE, 8, width of one byte/weight/bias element
WORD_BYTES, 26, bytes per SRAM word (25 weights + 1 bias)
WORD_WIDTH, 208, SRAM data width (WORD_BYTES*DATA_SIZE)
ADDR_WIDTH, 11, SRAM address width
BASE_ADDR, 1020, first SRAM address written
NUM_WORDS, 20, words per load (2 per output class, 10 classes)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
load_start  in  1  pulse; starts a load from IDLE or DONE
load_abort  in  1  pulse; cancels a load in progress
in_data  in  8  stream byte
in_vld  in  1  in_data valid
in_rdy  out  1  loader can accept a byte
wb_sram_enb  out  1  SRAM port-B enable
wb_sram_web  out  1  SRAM port-B write enable
wb_sram_addrb  out  11  SRAM port-B address
wb_sram_dinb  out  208  SRAM port-B write data
load_busy  out  1  high in FILL and WRITE
load_done  out  1  high in DONE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it overrides all other inputs in the cycle it is sampled.
- Reset values:
  - state = IDLE; in_rdy = 0; wb_sram_enb = 0; wb_sram_web = 0; wb_sram_addrb = 0; wb_sram_dinb = 0; load_busy = 0; load_done = 0.
  - byte_cnt = 0; word_idx = 0; shift register = 0.
- States:
  - IDLE -> FILL on load_start.
  - FILL -> WRITE when the 26th byte of a word is accepted.
  - WRITE -> FILL after a one-cycle write when word_idx < NUM_WORDS-1; otherwise WRITE -> DONE.
  - DONE -> FILL on load_start. On this restart, word_idx = 0, byte_cnt = 0 and load_done drops.
- Byte acceptance:
  - in_rdy is 1 only in FILL; it is decoded from the state register, never from in_vld.
  - A byte is accepted when in_vld & in_rdy are both high at a rising edge.
  - On acceptance: shift <= {shift[199:0], in_data}; byte_cnt increments.
  - The first byte of a word lands in bits [207:200]; the 26th byte (the bias) lands in bits [7:0].
  - An in_vld gap of any length stalls FILL with no state change.
- Word write:
  - The cycle after the 26th byte is accepted, the block is in WRITE for exactly one cycle.
  - In that cycle: enb = web = 1, addrb = BASE_ADDR + word_idx, dinb = the packed word.
  - byte_cnt clears to 0 and word_idx increments as WRITE is left.
  - In all other cycles enb and web are 0; addrb and dinb hold their last values.
- Word order: word 2k holds the upper 200 weight bits of class k; word 2k+1 holds the lower 200 bits and the bias of class k. Only the bias of word 2k+1 is meaningful; the bias of word 2k is don't-care but is still written.
- Throughput and latency:
  - Minimum 27 cycles per word with in_vld held high. in_rdy is low only in the WRITE cycle.
  - A full load takes at least 540 cycles.
  - load_done rises the cycle after the final write (address 1039) and stays high until load_start or rst.
- Outputs by state:
  - load_busy = 1 in FILL and WRITE.
  - load_done = 1 only in DONE.
- Boundary conditions:
  - load_start in FILL or WRITE: ignored.
  - load_abort in IDLE or DONE: ignored.
  - load_abort in FILL: go to IDLE, clear byte_cnt and word_idx. The byte presented that cycle is not accepted. No write is issued for the partial word.
  - load_abort in WRITE: the write in that cycle completes, then go to IDLE. load_done stays 0.
  - load_abort and load_start in the same cycle: abort wins.
  - rst mid-load: all outputs return to reset values the next cycle; SRAM contents are left as written.
- Arithmetic:
  - word_idx is 5 bits and byte_cnt is 5 bits; neither wraps during a valid load.
  - The address sum is ADDR_WIDTH bits wide; 1039 fits in 11 bits.

Test Plan:
- Reset: hold rst 3 cycles, with in_vld=1 and load_start=1 -> all outputs 0; no enb pulse.
- Full load: load_start, then 520 bytes 0x00,0x01,...,0x07 (mod 256), in_vld held high:
  - 20 single-cycle write pulses at addresses 1020..1039.
  - First dinb = 0x000102...19; last write's dinb[7:0] = 0x07.
  - load_done rises exactly one cycle after the 1039 write.
- Backpressure and gaps: random in_vld gaps (1-10 cycles) during the full load -> identical SRAM image to the no-gap run; in_rdy low only in WRITE cycles.
- Abort mid-word: abort after 13 bytes of word 3 -> no write to 1023; IDLE and load_busy=0 next cycle. A following load_start plus 520 bytes rewrites 1020..1039 correctly.
- Ignored start and restart:
  - load_start pulsed at byte 100 -> no effect, write count unchanged.
  - After DONE, load_start -> load_done drops next cycle and the next write targets 1020.
- Reset mid-write: assert rst in the WRITE cycle of word 7 -> outputs return to reset values next cycle; the word-7 write still occurs in that cycle (enb=1 at address 1027).
